// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: sequential step, stall hold,
// absolute/relative redirects and a circular return-address stack.
module pc_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int STEP      = 1,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_PC  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           redirect_valid,
    input  logic [1:0]                     redirect_mode,
    input  logic [ADDR_W-1:0]              redirect_target,
    input  logic [ADDR_W-1:0]              redirect_offset,
    input  logic                           clear_err,
    output logic [ADDR_W-1:0]              pc,
    output logic [ADDR_W-1:0]              pc_next,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_full,
    output logic                           ras_empty,
    output logic                           ras_overflow,
    output logic                           ras_underflow
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_PC);
    localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]  r_wp;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic              r_unf;

    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_pc_next;
    logic [PTR_W-1:0]  w_rd_ptr;
    logic [PTR_W-1:0]  w_wp_inc;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_set_ovf;
    logic              w_set_unf;

    assign w_seq    = r_pc + STEP_V;
    assign w_full   = (r_cnt == CNT_MAX);
    assign w_empty  = (r_cnt == {CNT_W{1'b0}});
    // r_wp names the next slot to write; the newest entry sits just below it.
    assign w_rd_ptr = (r_wp == {PTR_W{1'b0}}) ? PTR_MAX : (r_wp - PTR_W'(1));
    assign w_wp_inc = (r_wp == PTR_MAX) ? {PTR_W{1'b0}} : (r_wp + PTR_W'(1));

    // Next-PC selection and RAS push/pop/error decode.
    always_comb begin
        w_pc_next = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        if (redirect_valid) begin
            case (redirect_mode)
                2'b00: w_pc_next = redirect_target;
                2'b01: w_pc_next = r_pc + redirect_offset;
                2'b10: begin
                    w_pc_next = redirect_target;
                    w_push    = 1'b1;
                    w_set_ovf = w_full;
                end
                2'b11: begin
                    if (w_empty) begin
                        w_pc_next = redirect_target;
                        w_set_unf = 1'b1;
                    end else begin
                        w_pc_next = r_ras[w_rd_ptr];
                        w_pop     = 1'b1;
                    end
                end
                default: w_pc_next = r_pc;
            endcase
        end else if (stall) begin
            w_pc_next = r_pc;
        end else begin
            w_pc_next = w_seq;
        end
    end

    // PC, stack pointer, occupancy and sticky error state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc  <= RESET_V;
            r_wp  <= {PTR_W{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc  <= w_pc_next;
            r_ovf <= w_set_ovf | (r_ovf & ~clear_err);
            r_unf <= w_set_unf | (r_unf & ~clear_err);
            if (w_push) begin
                r_wp <= w_wp_inc;
                if (!w_full) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (w_pop) begin
                r_wp  <= w_rd_ptr;
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Return-address storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_ras[r_wp] <= w_seq;
        end
    end

    assign pc            = r_pc;
    assign pc_next       = w_pc_next;
    assign ras_count     = r_cnt;
    assign ras_full      = w_full;
    assign ras_empty     = w_empty;
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_pc_sequencer;

    localparam int AW    = 8;
    localparam int STEP  = 1;
    localparam int DEPTH = 4;
    localparam int RPC   = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       rv;
    logic [1:0] rm;
    logic [7:0] rt;
    logic [7:0] ro;
    logic       clr;
    logic [7:0] pc;
    logic [7:0] pc_next;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;

    int total = 0;
    int bad   = 0;

    int m_pc;
    int m_q[$];
    bit m_ovf;
    bit m_unf;

    pc_sequencer #(.ADDR_W(AW), .STEP(STEP), .RAS_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(rv), .redirect_mode(rm),
        .redirect_target(rt), .redirect_offset(ro),
        .clear_err(clr),
        .pc(pc), .pc_next(pc_next), .ras_count(cnt),
        .ras_full(full), .ras_empty(empty),
        .ras_overflow(ovf), .ras_underflow(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_next();
        int off;
        if (rv) begin
            case (rm)
                2'd0: return int'(rt);
                2'd1: begin
                    off = (ro >= 8'd128) ? int'(ro) - 256 : int'(ro);
                    return (m_pc + off + 256) % 256;
                end
                2'd2: return int'(rt);
                default: return (m_q.size() > 0) ? m_q[$] : int'(rt);
            endcase
        end
        if (stall) return m_pc;
        return (m_pc + STEP) % 256;
    endfunction

    task automatic model_reset();
        m_pc = RPC;
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_edge();
        int nxt;
        bit so;
        bit su;
        nxt = exp_next();
        so = 1'b0;
        su = 1'b0;
        if (rv && rm == 2'd2) begin
            if (m_q.size() == DEPTH) begin
                void'(m_q.pop_front());
                so = 1'b1;
            end
            m_q.push_back((m_pc + STEP) % 256);
        end
        if (rv && rm == 2'd3) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else su = 1'b1;
        end
        m_ovf = so | (m_ovf & !clr);
        m_unf = su | (m_unf & !clr);
        m_pc  = nxt;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".pc"},    int'(pc),    m_pc);
        chk({tag, ".cnt"},   int'(cnt),   m_q.size());
        chk({tag, ".full"},  int'(full),  int'(m_q.size() == DEPTH));
        chk({tag, ".empty"}, int'(empty), int'(m_q.size() == 0));
        chk({tag, ".ovf"},   int'(ovf),   int'(m_ovf));
        chk({tag, ".unf"},   int'(unf),   int'(m_unf));
    endtask

    // Inputs are set shortly after a rising edge; pc_next is sampled mid-cycle.
    task automatic cycle(input string tag);
        #1;
        chk({tag, ".pc_next"}, int'(pc_next), exp_next());
        @(posedge clk);
        model_edge();
        #1;
        check_state(tag);
    endtask

    task automatic drive(input bit v, input logic [1:0] m, input logic [7:0] t,
                         input logic [7:0] o, input bit s, input bit c, input string tag);
        rv = v; rm = m; rt = t; ro = o; stall = s; clr = c;
        cycle(tag);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; rv = 1'b0; rm = 2'd0; rt = 8'h00; ro = 8'h00; clr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_state("reset");
        chk("reset.pc0", int'(pc), 0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, "inc");
            chk("inc.abs", int'(pc), i + 1);
        end
        drive(1'b1, 2'd0, 8'hFF, 8'h00, 1'b0, 1'b0, "jmpff");
        drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, "wrap");
        chk("wrap.abs", int'(pc), 8'h00);

        drive(1'b1, 2'd0, 8'h10, 8'h00, 1'b0, 1'b0, "jmp10");
        drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, "stall1");
        drive(1'b0, 2'd3, 8'h77, 8'h00, 1'b1, 1'b0, "stall2");
        chk("stall.abs", int'(pc), 8'h10);
        drive(1'b1, 2'd0, 8'h40, 8'h00, 1'b1, 1'b0, "stalljmp");
        chk("stalljmp.abs", int'(pc), 8'h40);

        drive(1'b1, 2'd0, 8'h20, 8'h00, 1'b0, 1'b0, "jmp20");
        drive(1'b1, 2'd1, 8'h00, 8'hF8, 1'b0, 1'b0, "brneg");
        chk("brneg.abs", int'(pc), 8'h18);
        drive(1'b1, 2'd0, 8'hFC, 8'h00, 1'b0, 1'b0, "jmpfc");
        drive(1'b1, 2'd1, 8'h00, 8'h08, 1'b0, 1'b0, "brwrap");
        chk("brwrap.abs", int'(pc), 8'h04);

        drive(1'b1, 2'd0, 8'h05, 8'h00, 1'b0, 1'b0, "jmp05");
        drive(1'b1, 2'd2, 8'h30, 8'h00, 1'b0, 1'b0, "call1");
        chk("call1.cnt", int'(cnt), 1);
        drive(1'b1, 2'd2, 8'h50, 8'h00, 1'b0, 1'b0, "call2");
        chk("call2.cnt", int'(cnt), 2);
        drive(1'b1, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0, "ret1");
        chk("ret1.pc", int'(pc), 8'h31);
        chk("ret1.cnt", int'(cnt), 1);
        drive(1'b1, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0, "ret2");
        chk("ret2.pc", int'(pc), 8'h06);
        chk("ret2.cnt", int'(cnt), 0);

        drive(1'b1, 2'd0, 8'h01, 8'h00, 1'b0, 1'b0, "jmp01");
        for (int i = 1; i <= 5; i++) drive(1'b1, 2'd2, 8'(i + 1), 8'h00, 1'b0, 1'b0, "ovcall");
        chk("ov.flag", int'(ovf), 1);
        chk("ov.cnt", int'(cnt), 4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd3, 8'hAA, 8'h00, 1'b0, 1'b0, "ovret");
            chk("ovret.abs", int'(pc), 6 - i);
        end
        drive(1'b1, 2'd3, 8'hAA, 8'h00, 1'b0, 1'b0, "unret");
        chk("unret.pc", int'(pc), 8'hAA);
        chk("unret.flag", int'(unf), 1);
        drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, "clr");
        chk("clr.ovf", int'(ovf), 0);
        chk("clr.unf", int'(unf), 0);

        drive(1'b1, 2'd2, 8'h60, 8'h00, 1'b0, 1'b0, "precall");
        rv = 1'b1; rm = 2'd2; rt = 8'h90; stall = 1'b0; clr = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst.pc", int'(pc), RPC);
        chk("arst.cnt", int'(cnt), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_state("arst");
        drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, "postrst");
        chk("postrst.cnt", int'(cnt), 0);

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 45), 2'($urandom_range(0, 3)), 8'($urandom),
                  8'($urandom), ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 10), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
